// File: rtl/card_pkg.sv
// Shared constants and types for the memory-game card path (shuffler and dealer).
package card_pkg;
    localparam int NUM_CARDS = 20;
    localparam int SLOT_W    = $clog2(NUM_CARDS);
    localparam int FACE_W    = $clog2(NUM_CARDS / 2);
    // Seen mask covers every value a SLOT_W field can hold, so a masked
    // lookup is always in bounds even before the range test rejects it.
    localparam int MASK_W    = 1 << SLOT_W;

    typedef logic [SLOT_W-1:0]  slot_t;
    typedef logic [FACE_W-1:0]  face_t;
    typedef logic signed [31:0] card_val_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        DEAL  = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } dealer_state_e;

    // Pairs share a face: ids 2f and 2f+1 both show face f.
    function automatic face_t face_of(input card_val_t v);
        return face_t'(v[SLOT_W-1:1]);
    endfunction
endpackage

// File: rtl/card_dealer_perm_checker.sv
// Walks the snapshot one entry per step, rejecting out-of-range or repeated ids.
module perm_checker
    import card_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      start_i,
    input  logic      step_i,
    input  card_val_t entries_i [NUM_CARDS],
    output logic      done_o,
    output logic      err_o
);
    slot_t             idx_q;
    logic [MASK_W-1:0] seen_q;
    card_val_t         val;
    logic              bad;

    assign val = entries_i[idx_q];

    // Entry under test is bad if negative, too large, or already used.
    always_comb begin
        bad    = (val < 0) || (val >= NUM_CARDS) || seen_q[val[SLOT_W-1:0]];
        err_o  = step_i && bad;
        done_o = step_i && !bad && (idx_q == slot_t'(NUM_CARDS - 1));
    end

    // Mark each accepted id and advance; start wipes the history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            seen_q <= '0;
        end else if (start_i) begin
            idx_q  <= '0;
            seen_q <= '0;
        end else if (step_i && !bad) begin
            seen_q[val[SLOT_W-1:0]] <= 1'b1;
            idx_q                   <= idx_q + slot_t'(1);
        end
    end
endmodule

// File: rtl/card_dealer.sv
// Snapshots a shuffled order, validates it, then deals positions over valid/ready.
module card_dealer
    import card_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  card_val_t         card_order [NUM_CARDS],
    input  logic              load,
    input  logic              restart,
    output logic              card_valid,
    input  logic              card_ready,
    output logic [SLOT_W-1:0] card_slot,
    output logic [FACE_W-1:0] card_face,
    output logic [SLOT_W:0]   cards_left,
    output logic              busy,
    output logic              order_ok,
    output logic              order_err
);
    dealer_state_e     state_q, state_d;
    card_val_t         snap_q [NUM_CARDS];
    slot_t             didx_q, didx_d, nidx;
    logic [SLOT_W:0]   left_q, left_d;
    logic              valid_q, valid_d;
    slot_t             slot_q, slot_d;
    face_t             face_q, face_d;
    logic              ok_q, ok_d, err_q, err_d, busy_q, busy_d;
    logic              load_acc, rewind, chk_done, chk_err;

    assign load_acc = load && (state_q == IDLE || state_q == DONE || state_q == ERROR);
    assign rewind   = restart && (state_q == DEAL || state_q == DONE);
    assign nidx     = didx_q + slot_t'(1);

    perm_checker u_chk (
        .clk       (clk),
        .rst       (rst),
        .start_i   (load_acc),
        .step_i    (state_q == CHECK),
        .entries_i (snap_q),
        .done_o    (chk_done),
        .err_o     (chk_err)
    );

    // Next-state logic; load outranks restart, restart outranks a same-edge transfer.
    always_comb begin
        state_d = state_q;
        didx_d  = didx_q;
        left_d  = left_q;
        valid_d = valid_q;
        slot_d  = slot_q;
        face_d  = face_q;
        ok_d    = ok_q;
        err_d   = err_q;
        busy_d  = busy_q;
        if (load_acc) begin
            state_d = CHECK;
            ok_d    = 1'b0;
            err_d   = 1'b0;
            busy_d  = 1'b1;
            valid_d = 1'b0;
        end else if (rewind || (state_q == CHECK && chk_done)) begin
            state_d = DEAL;
            didx_d  = '0;
            left_d  = (SLOT_W+1)'(NUM_CARDS);
            valid_d = 1'b1;
            slot_d  = '0;
            face_d  = face_of(snap_q[0]);
            if (state_q == CHECK) begin
                ok_d   = 1'b1;
                busy_d = 1'b0;
            end
        end else if (state_q == CHECK && chk_err) begin
            state_d = ERROR;
            err_d   = 1'b1;
            busy_d  = 1'b0;
        end else if (state_q == DEAL && card_ready) begin
            if (didx_q == slot_t'(NUM_CARDS - 1)) begin
                state_d = DONE;
                valid_d = 1'b0;
                left_d  = '0;
            end else begin
                didx_d = nidx;
                left_d = left_q - 1'b1;
                slot_d = nidx;
                face_d = face_of(snap_q[nidx]);
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            didx_q  <= '0;
            left_q  <= '0;
            valid_q <= 1'b0;
            slot_q  <= '0;
            face_q  <= '0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            didx_q  <= didx_d;
            left_q  <= left_d;
            valid_q <= valid_d;
            slot_q  <= slot_d;
            face_q  <= face_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // Order snapshot, captured only when a load is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CARDS; i++) snap_q[i] <= '0;
        end else if (load_acc) begin
            for (int i = 0; i < NUM_CARDS; i++) snap_q[i] <= card_order[i];
        end
    end

    assign card_valid = valid_q;
    assign card_slot  = slot_q;
    assign card_face  = face_q;
    assign cards_left = left_q;
    assign busy       = busy_q;
    assign order_ok   = ok_q;
    assign order_err  = err_q;
endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: vector table, corner sequences, random orders.
module tb_card_dealer;
    import card_pkg::*;

    typedef int order_t [NUM_CARDS];
    typedef struct {
        int swap_a;
        int swap_b;
        int pos;
        int val;
        int exp_k;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic signed [31:0] card_order [NUM_CARDS];
    logic              load = 1'b0, restart = 1'b0, card_ready = 1'b0;
    logic              card_valid, busy, order_ok, order_err;
    logic [SLOT_W-1:0] card_slot;
    logic [FACE_W-1:0] card_face;
    logic [SLOT_W:0]   cards_left;
    int                checks = 0, failures = 0;

    card_dealer dut (
        .clk(clk), .rst(rst), .card_order(card_order), .load(load), .restart(restart),
        .card_valid(card_valid), .card_ready(card_ready), .card_slot(card_slot),
        .card_face(card_face), .cards_left(cards_left), .busy(busy),
        .order_ok(order_ok), .order_err(order_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: index of the first entry that breaks the permutation, or -1.
    function automatic int first_bad(input order_t o);
        bit seen [NUM_CARDS];
        for (int i = 0; i < NUM_CARDS; i++) seen[i] = 1'b0;
        for (int i = 0; i < NUM_CARDS; i++) begin
            if (o[i] < 0 || o[i] >= NUM_CARDS) return i;
            if (seen[o[i]]) return i;
            seen[o[i]] = 1'b1;
        end
        return -1;
    endfunction

    function automatic order_t identity();
        order_t o;
        for (int i = 0; i < NUM_CARDS; i++) o[i] = i;
        return o;
    endfunction

    task automatic drive_order(input order_t o);
        for (int i = 0; i < NUM_CARDS; i++) card_order[i] = o[i];
    endtask

    task automatic do_load(input order_t o);
        drive_order(o);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic chk_card(input string nm, input int p, input order_t o);
        chk({nm, " valid"}, card_valid, 1);
        chk({nm, " slot"},  card_slot,  p);
        chk({nm, " face"},  card_face,  o[p] >> 1);
        chk({nm, " left"},  cards_left, NUM_CARDS - p);
    endtask

    // Called one negedge after the load edge; checks CHECK duration and verdict.
    task automatic check_verdict(input string nm, input order_t o, input int exp_k);
        if (exp_k < 0) begin
            repeat (NUM_CARDS - 1) @(negedge clk);
            chk({nm, " busy late"},  busy, 1);
            chk({nm, " early vld"}, card_valid, 0);
            @(negedge clk);
            chk({nm, " ok"},   order_ok, 1);
            chk({nm, " busy"}, busy, 0);
            chk({nm, " err"},  order_err, 0);
            chk_card({nm, " first"}, 0, o);
        end else begin
            repeat (exp_k) @(negedge clk);
            chk({nm, " err early"}, order_err, 0);
            chk({nm, " busy chk"},  busy, 1);
            @(negedge clk);
            chk({nm, " err"},  order_err, 1);
            chk({nm, " busy"}, busy, 0);
            chk({nm, " ok"},   order_ok, 0);
            card_ready = 1'b1;
            repeat (3) @(negedge clk);
            chk({nm, " err held"}, order_err, 1);
            chk({nm, " no vld"},   card_valid, 0);
            card_ready = 1'b0;
        end
    endtask

    // mode 0: ready always high, 1: random ready, 2: 5-cycle stall at slot 4.
    task automatic deal_all(input string nm, input order_t o, input int mode, input int start_p);
        int p, stall, cyc;
        bit r;
        p = start_p; stall = 0; cyc = 0;
        while (p < NUM_CARDS && cyc < 400) begin
            chk_card(nm, p, o);
            if (mode == 0) r = 1'b1;
            else if (mode == 1) r = 1'($urandom_range(0, 1));
            else r = !(p == 4 && stall < 5);
            if (!r && mode == 2) stall++;
            card_ready = r;
            @(negedge clk);
            if (r) p++;
            cyc++;
        end
        card_ready = 1'b0;
        chk({nm, " completed"}, p, NUM_CARDS);
        if (mode == 0) chk({nm, " cycles"}, cyc, NUM_CARDS - start_p);
        if (mode == 2) chk({nm, " stall"}, stall, 5);
        chk({nm, " done vld"},  card_valid, 0);
        chk({nm, " done left"}, cards_left, 0);
        chk({nm, " done ok"},   order_ok, 1);
    endtask

    initial begin
        vec_t   tbl [8];
        order_t o, o2;
        int     k, a, b, t;

        tbl[0] = '{-1, -1, -1,  0, -1};
        tbl[1] = '{ 3,  5,  7,  5,  7};
        tbl[2] = '{-1, -1,  0, 20,  0};
        tbl[3] = '{-1, -1, 12, -1, 12};
        tbl[4] = '{-1, -1, 19,  0, 19};
        tbl[5] = '{-1, -1, 10, -2147483647 - 1, 10};
        tbl[6] = '{-1, -1,  5, 31,  5};
        tbl[7] = '{ 0, 19, -1,  0, -1};
        drive_order(identity());

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst valid", card_valid, 0);
        chk("rst slot",  card_slot, 0);
        chk("rst face",  card_face, 0);
        chk("rst left",  cards_left, 0);
        chk("rst busy",  busy, 0);
        chk("rst ok",    order_ok, 0);
        chk("rst err",   order_err, 0);
        rst = 1'b0;
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        @(negedge clk);
        chk("idle restart vld", card_valid, 0);

        // Vector table
        for (int v = 0; v < 8; v++) begin
            o = identity();
            if (tbl[v].swap_a >= 0) begin
                t = o[tbl[v].swap_a]; o[tbl[v].swap_a] = o[tbl[v].swap_b]; o[tbl[v].swap_b] = t;
            end
            if (tbl[v].pos >= 0) o[tbl[v].pos] = tbl[v].val;
            do_load(o);
            check_verdict($sformatf("vec%0d", v), o, tbl[v].exp_k);
            if (tbl[v].exp_k < 0) deal_all($sformatf("vec%0d deal", v), o, 0, 0);
        end

        // Stall on slot 4 with shuffled order 19,0,1,...
        for (int i = 0; i < NUM_CARDS; i++) o[i] = (i == 0) ? NUM_CARDS - 1 : i - 1;
        do_load(o);
        check_verdict("stall", o, -1);
        deal_all("stall deal", o, 2, 0);

        // Restart after 6 transfers, then load ignored during DEAL
        for (int i = 0; i < NUM_CARDS; i++) o[i] = (i * 7) % NUM_CARDS;
        for (int i = 0; i < NUM_CARDS; i++) o2[i] = NUM_CARDS - 1 - i;
        do_load(o);
        check_verdict("rw", o, -1);
        card_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk_card("rw six", 6, o);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk_card("rw rewound", 0, o);
        drive_order(o2);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("rw load ign busy", busy, 0);
        chk_card("rw load ign", 1, o);
        deal_all("rw rest", o, 0, 1);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk_card("done restart", 0, o);
        deal_all("done redeal", o, 1, 0);
        drive_order(o2);
        load = 1'b1; restart = 1'b1;
        @(negedge clk);
        load = 1'b0; restart = 1'b0;
        chk("ld+rs busy", busy, 1);
        chk("ld+rs vld",  card_valid, 0);
        chk("ld+rs ok",   order_ok, 0);
        check_verdict("ld+rs", o2, -1);

        // Asynchronous reset mid-deal
        card_ready = 1'b1;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst valid", card_valid, 0);
        chk("arst slot",  card_slot, 0);
        chk("arst face",  card_face, 0);
        chk("arst left",  cards_left, 0);
        chk("arst ok",    order_ok, 0);
        @(negedge clk);
        rst = 1'b0;
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        repeat (2) @(negedge clk);
        chk("post rst vld",  card_valid, 0);
        chk("post rst busy", busy, 0);
        chk("post rst left", cards_left, 0);
        card_ready = 1'b0;

        // Random orders against the reference model
        for (int it = 0; it < 12; it++) begin
            o = identity();
            for (int i = NUM_CARDS - 1; i > 0; i--) begin
                a = int'($urandom_range(0, i));
                t = o[i]; o[i] = o[a]; o[a] = t;
            end
            case ($urandom_range(0, 2))
                1: begin
                    a = int'($urandom_range(0, NUM_CARDS - 1));
                    o[a] = ($urandom_range(0, 1) == 1) ? -1 - int'($urandom_range(0, 4))
                                                       : NUM_CARDS + int'($urandom_range(0, 20));
                end
                2: begin
                    a = int'($urandom_range(0, NUM_CARDS - 1));
                    b = int'($urandom_range(0, NUM_CARDS - 1));
                    if (a == b) b = (a + 1) % NUM_CARDS;
                    o[a] = o[b];
                end
                default: ;
            endcase
            k = first_bad(o);
            do_load(o);
            check_verdict($sformatf("rnd%0d", it), o, k);
            if (k < 0) deal_all($sformatf("rnd%0d deal", it), o, 1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/card_dealer.md
Name: card_dealer

Overview:
Reader side of the shuffled card-order array that the shuffler produces for the memory game board. On a load pulse the block snapshots the 20-entry order and checks that it is a true permutation of 0..NUM_CARDS-1. It then deals board positions one per valid/ready transfer, each tagged with its pair face, to the board/display logic. A bad order is flagged and never dealt.

Parameters:
NUM_CARDS, 20, number of board positions and card ids (even, ≤32)
SLOT_W, 5, width of position/card-id fields (clog2 NUM_CARDS)
FACE_W, 4, width of pair-face id (clog2 NUM_CARDS/2)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
card_order  in  int [NUM_CARDS]  card id placed at each board position
load  in  1  pulse: snapshot card_order, start check
restart  in  1  pulse: rewind dealing to position 0, no recheck
card_valid  out  1  dealt card presented
card_ready  in  1  consumer accepts card
card_slot  out  SLOT_W  board position of presented card
card_face  out  FACE_W  pair face = card id >> 1
cards_left  out  SLOT_W+1  cards not yet transferred
busy  out  1  in CHECK
order_ok  out  1  snapshot is a valid permutation
order_err  out  1  snapshot rejected

Behaviour:
- Reset (async, any state): state IDLE, card_valid=0, card_slot=0, card_face=0, cards_left=0, busy=0, order_ok=0, order_err=0; snapshot, seen mask, and idx cleared.
- States: IDLE, CHECK, DEAL, DONE, ERROR.
- load is accepted in IDLE, DONE, or ERROR. On the accepting edge:
  - snapshot all entries (full 32-bit values retained for the range check);
  - idx=0, seen=0, order_ok=0, order_err=0; go to CHECK (busy=1).
- load is ignored in CHECK and DEAL.
- CHECK examines entry idx each cycle:
  - If value<0, value≥NUM_CARDS, or seen[value]=1: go to ERROR, order_err=1, busy=0.
  - Otherwise set seen[value] and idx++.
  - After entry NUM_CARDS-1 passes: go to DEAL, idx=0, cards_left=NUM_CARDS, order_ok=1, busy=0.
- Check timing: a valid order occupies exactly NUM_CARDS CHECK cycles. If load is sampled at edge t, card_valid first rises after edge t+NUM_CARDS. An error at entry k is flagged after edge t+k+1.
- DEAL: card_valid=1, card_slot=idx, card_face=snapshot[idx]>>1.
  - Transfer occurs when card_valid&card_ready at a rising edge: idx++, cards_left--.
  - While card_valid=1 and card_ready=0, card_slot/card_face/cards_left hold stable.
  - The transfer of position NUM_CARDS-1 moves to DONE with card_valid=0 and cards_left=0. No extra idle cycle is inserted between transfers (1 card/cycle with ready held high).
- restart in DEAL or DONE: idx=0, cards_left=NUM_CARDS, go to DEAL (or stay in DEAL). A transfer on the same edge is discarded. restart is ignored in IDLE, CHECK, and ERROR.
- load and restart on the same edge in DONE: load wins.
- ERROR holds order_err=1 and card_valid=0 until load or rst.
- order_ok stays 1 through DEAL and DONE; it clears only on load or rst.
- Width rules:
  - Comparisons use signed 32-bit values.
  - card_slot is idx truncated to SLOT_W.
  - card_face is the snapshot value bits [SLOT_W-1:1].
- All outputs are registered; there is no combinational path from card_ready to card_valid.

Decomposition:
- Shared package card_pkg holds:
  - NUM_CARDS, SLOT_W, and FACE_W constants, which the shuffler also uses;
  - typedef slot_t (logic [SLOT_W-1:0]);
  - typedef face_t;
  - the dealer_state_e enum (IDLE, CHECK, DEAL, DONE, ERROR).
- One sub-module, perm_checker, holds the seen mask, the check index, and the range/duplicate compare. It has start/done/err outputs and is driven by the card_dealer FSM.

Test Plan:
1. Identity order 0..19, load, card_ready=1 -> card_valid rises after 20 CHECK cycles; faces dealt 0,0,1,1,…,9,9 on slots 0..19 in 20 consecutive cycles; then DONE with cards_left=0 and order_ok=1.
2. Order with entry 7 equal to entry 3 (value 5) -> order_err=1 after the 8th CHECK cycle; card_valid never asserts; a following valid load recovers to DEAL.
3. Entry 0 = 20, then separately entry 12 = -1 -> order_err after 1 and 13 CHECK cycles respectively.
4. Shuffled order [19,0,…], card_ready low for 5 cycles at slot 4 -> slot/face/cards_left (16) stable and card_valid held; resumes at slot 4 when card_ready rises.
5. restart after 6 transfers -> next card is slot 0 with cards_left=20. load asserted during DEAL -> ignored, dealing continues.
6. rst pulsed mid-DEAL, asynchronously between clock edges -> all outputs zero immediately; IDLE until the next load.
